// File: rtl/dpram_arb_pkg.sv
// ============================================================================
// Module   : dpram_arb_pkg
// Brief    : Shared types, default widths and helpers for the dual-port RAM arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dpram_arb_pkg;

  localparam int c_ADDR_W = 8;
  localparam int c_DATA_W = 8;
  localparam int c_RD_LAT = 1;

  typedef enum logic {
    CLI_A = 1'b0,
    CLI_B = 1'b1
  } client_e;

  // One slot of the read-return pipeline: who issued the read and whether it is live.
  typedef struct packed {
    logic    valid;
    client_e owner;
  } rd_tag_t;

  function automatic client_e other_client(input client_e c);
    return (c == CLI_A) ? CLI_B : CLI_A;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ============================================================================
// Module   : rr_arb2
// Brief    : Two-way round-robin arbiter; clients in their grant cycle are masked.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb2
  import dpram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] i_req,
  input  logic [1:0] i_mask,
  output logic [1:0] o_gnt,
  output logic       o_valid,
  output client_e    o_win
);

  client_e    r_ptr;
  logic [1:0] w_elig;

  always_comb begin
    w_elig  = i_req & ~i_mask;
    o_valid = |w_elig;
    o_win   = r_ptr;
    if (!w_elig[r_ptr]) o_win = other_client(r_ptr);
    o_gnt = 2'b00;
    if (o_valid) o_gnt[o_win] = 1'b1;
  end

  // After any grant the loser becomes the favourite.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       r_ptr <= CLI_A;
    else if (o_valid) r_ptr <= other_client(o_win);
  end

endmodule

`default_nettype wire

// File: rtl/dpram_arbiter.sv
// ============================================================================
// Module   : dpram_arbiter
// Brief    : Arbitrates two clients onto the write and read ports of one dual-port
//            RAM and routes read data back to the issuing client.
// Options  : DPRAM_BYPASS_EN - same-cycle same-address write/read returns write data
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dpram_arbiter
  import dpram_arb_pkg::*;
#(
  parameter int ADDR_W = c_ADDR_W,
  parameter int DATA_W = c_DATA_W,
  parameter int RD_LAT = c_RD_LAT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_a,
  input  logic              req_b,
  input  logic              wr_a,
  input  logic              wr_b,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_a,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              gnt_a,
  output logic              gnt_b,
  output logic              rvalid_a,
  output logic              rvalid_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_add_wr,
  output logic              ram_re,
  output logic [ADDR_W-1:0] ram_read_wr,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out
);

  logic [1:0]        w_wr_req, w_rd_req, w_wr_gnt, w_rd_gnt;
  logic              w_wr_any, w_rd_any;
  client_e           w_wr_win, w_rd_win;
  logic [1:0]        r_gnt;
  logic              r_we, r_re;
  logic [ADDR_W-1:0] r_add_wr, r_read_wr;
  logic [DATA_W-1:0] r_data_in, r_last_a, r_last_b, w_rdata;
  client_e           r_re_owner;
  rd_tag_t           r_tag [RD_LAT];
  rd_tag_t           w_tag_in, w_ret;

  assign w_wr_req = {req_b &  wr_b, req_a &  wr_a};
  assign w_rd_req = {req_b & ~wr_b, req_a & ~wr_a};

  rr_arb2 u_wr_arb (
    .clk     (clk),
    .reset   (reset),
    .i_req   (w_wr_req),
    .i_mask  (r_gnt),
    .o_gnt   (w_wr_gnt),
    .o_valid (w_wr_any),
    .o_win   (w_wr_win)
  );

  rr_arb2 u_rd_arb (
    .clk     (clk),
    .reset   (reset),
    .i_req   (w_rd_req),
    .i_mask  (r_gnt),
    .o_gnt   (w_rd_gnt),
    .o_valid (w_rd_any),
    .o_win   (w_rd_win)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_gnt      <= 2'b00;
      r_we       <= 1'b0;
      r_add_wr   <= '0;
      r_data_in  <= '0;
      r_re       <= 1'b0;
      r_read_wr  <= '0;
      r_re_owner <= CLI_A;
    end else begin
      r_gnt      <= w_wr_gnt | w_rd_gnt;
      r_we       <= w_wr_any;
      r_add_wr   <= w_wr_any ? ((w_wr_win == CLI_A) ? addr_a  : addr_b)  : '0;
      r_data_in  <= w_wr_any ? ((w_wr_win == CLI_A) ? wdata_a : wdata_b) : '0;
      r_re       <= w_rd_any;
      r_read_wr  <= w_rd_any ? ((w_rd_win == CLI_A) ? addr_a  : addr_b)  : '0;
      r_re_owner <= w_rd_win;
    end
  end

  always_comb begin
    w_tag_in       = '0;
    w_tag_in.valid = r_re;
    w_tag_in.owner = r_re_owner;
  end

  // Tag enters as the RAM samples ram_re; it emerges with the RAM's read data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < RD_LAT; i++) r_tag[i] <= '0;
    end else begin
      r_tag[0] <= w_tag_in;
      for (int i = 1; i < RD_LAT; i++) r_tag[i] <= r_tag[i-1];
    end
  end

`ifdef DPRAM_BYPASS_EN
  logic              r_byp      [RD_LAT];
  logic [DATA_W-1:0] r_byp_data [RD_LAT];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < RD_LAT; i++) begin
        r_byp[i]      <= 1'b0;
        r_byp_data[i] <= '0;
      end
    end else begin
      r_byp[0]      <= r_we && r_re && (r_add_wr == r_read_wr);
      r_byp_data[0] <= r_data_in;
      for (int i = 1; i < RD_LAT; i++) begin
        r_byp[i]      <= r_byp[i-1];
        r_byp_data[i] <= r_byp_data[i-1];
      end
    end
  end

  assign w_rdata = r_byp[RD_LAT-1] ? r_byp_data[RD_LAT-1] : ram_data_out;
`else
  assign w_rdata = ram_data_out;
`endif

  assign w_ret    = r_tag[RD_LAT-1];
  assign rvalid_a = w_ret.valid && (w_ret.owner == CLI_A);
  assign rvalid_b = w_ret.valid && (w_ret.owner == CLI_B);
  assign rdata_a  = rvalid_a ? w_rdata : r_last_a;
  assign rdata_b  = rvalid_b ? w_rdata : r_last_b;

  // The idle client's rdata keeps showing its last returned word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_a <= '0;
      r_last_b <= '0;
    end else begin
      if (rvalid_a) r_last_a <= w_rdata;
      if (rvalid_b) r_last_b <= w_rdata;
    end
  end

  assign gnt_a       = r_gnt[0];
  assign gnt_b       = r_gnt[1];
  assign ram_we      = r_we;
  assign ram_add_wr  = r_add_wr;
  assign ram_data_in = r_data_in;
  assign ram_re      = r_re;
  assign ram_read_wr = r_read_wr;

endmodule

`default_nettype wire
